cu_multicycle: RTL
==================

CU_MULTICYCLE -- requirements
Module: cu_multicycle

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning the width of register, operand and offset data.
REQ-002 SHALL have parameter REG_ADDR_BITS, default 2, meaning the register-index width; the register file holds NUM_REGS = 2^REG_ADDR_BITS entries.
REQ-003 SHALL have parameter MEM_TIMEOUT, default 16, meaning the maximum number of MEM_ACCESS cycles before abort; 0 disables the timeout.
REQ-004 SHALL have derived parameter INSTR_WIDTH = 6 + 3*REG_ADDR_BITS + DATA_WIDTH, which is 20 at the defaults.
REQ-005 SHALL use one clock; reset is asynchronous and active-low.
REQ-006 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset.
- instr  in  INSTR_WIDTH  instruction, fields MSB to LSB: class[2], rd, rs1, rs2, offset[DATA_WIDTH], alu_op[4].
- instr_valid  in  1  instr is presented.
- instr_ready  out  1  block accepts an instruction.
- result2  in  DATA_WIDTH  ALU result or memory read data.
- mem_ack  in  1  memory completed the access.
- operand1  out  DATA_WIDTH  first operand.
- operand2  out  DATA_WIDTH  second operand.
- offset  out  DATA_WIDTH  immediate offset.
- opcode  out  4  ALU op.
- sel1  out  1  datapath mux select.
- sel3  out  1  datapath mux select.
- w_r  out  1  memory write strobe.
- mem_req  out  1  memory access request.
- busy  out  1  instruction in flight.
- done  out  1  completion pulse.
- err  out  1  timeout-abort pulse.
- dbg_addr  in  REG_ADDR_BITS  debug read index.
- dbg_data  out  DATA_WIDTH  combinational register-file read of dbg_addr.

Function
REQ-007 SHALL decode class values as: 00 NOP, 01 std_op, 10 load, 11 store.
REQ-008 SHALL implement states IDLE, DECODE, EXECUTE, MEM_ACCESS and WRITE_BACK; any unreachable encoding SHALL return to IDLE on the next edge.
REQ-009 SHALL drive instr_ready=1 only in IDLE, and busy = (state != IDLE).
REQ-010 SHALL accept an instruction on a clk edge with instr_valid & instr_ready, latching it into an internal register; instr SHALL be ignored at all other times.
REQ-011 SHALL consume an accepted NOP with no state change, no done, no register write and no output change.
REQ-012 SHALL move an accepted non-NOP instruction IDLE -> DECODE.
REQ-013 SHALL, on DECODE -> EXECUTE, register the operand outputs and hold them until the next accepted non-NOP instruction:
- std_op: operand1=R[rs1], operand2=R[rs2], sel1=1, sel3=0.
- load/store: operand1=R[rs1], operand2=R[rd], sel1=0, sel3=1.
- all classes: offset=instr offset field, opcode=alu_op.
REQ-014 SHALL transition EXECUTE -> WRITE_BACK for std_op and EXECUTE -> MEM_ACCESS for load or store.
REQ-015 SHALL, in MEM_ACCESS, drive mem_req=1, drive w_r=1 for store only, and count cycles spent in the state.
REQ-016 SHALL, on a MEM_ACCESS edge with mem_ack=1, transition load -> WRITE_BACK and store -> IDLE with done.
REQ-017 SHALL, when MEM_TIMEOUT>0 and MEM_TIMEOUT cycles elapse in MEM_ACCESS with no mem_ack, transition to IDLE with no register write and pulse err; mem_ack present on the last cycle SHALL take priority over the timeout.
REQ-018 SHALL, on the WRITE_BACK -> IDLE edge, write R[rd] <= result2 for both std_op and load.
REQ-019 SHALL register done and err so that each is high for exactly the first IDLE cycle after completion or abort.
REQ-020 SHALL allow a new instruction to be accepted in the same cycle that done or err is high.
REQ-021 SHALL keep w_r=0 and mem_req=0 outside MEM_ACCESS and ignore mem_ack outside MEM_ACCESS.
REQ-022 SHALL have a latency from acceptance edge to done-high cycle of 4 clocks for std_op, 4+N clocks for a store and 5+N clocks for a load, where N is the number of MEM_ACCESS wait cycles before mem_ack (N=0 when mem_ack is already high).

Reset
REQ-023 SHALL, on asserting rst=0 at any time (including mid-instruction), immediately set:
- state=IDLE;
- R[i]=i (truncated to DATA_WIDTH);
- operand1, operand2 and offset = 0;
- opcode=4'hF;
- sel1, sel3, w_r, mem_req, done and err = 0;
- the timeout counter cleared.
REQ-024 SHALL leave no partial register write pending after reset.

Verification
REQ-025 Reset, then std_op rd=1, rs1=2, rs2=3, alu_op=0, with result2=5 -> operand1=2, operand2=3, sel1=1; done high 4 clocks after acceptance; dbg R[1]=5.
REQ-026 Load rd=2, rs1=1, offset=8'h04, with mem_ack held off 3 cycles and result2=8'hA5 -> mem_req high for 4 cycles, w_r=0; R[2]=A5; done at 8 clocks.
REQ-027 Store rd=3, rs1=0, with immediate mem_ack -> w_r=1 for exactly 1 cycle, operand2=3, no register changes, done at 4 clocks.
REQ-028 Load with mem_ack never asserted, MEM_TIMEOUT=16 -> 16 MEM_ACCESS cycles, then err pulse, R unchanged, done never high.
REQ-029 rst asserted in MEM_ACCESS of a store -> w_r and mem_req fall immediately, R[i]=i, state IDLE; next std_op executes normally.
REQ-030 NOP followed by back-to-back std_ops with instr_valid held high -> NOP produces no done; the second std_op is accepted in the same cycle as the first one's done.

Source files
------------

// File: rtl/cu_multicycle.sv
// Multicycle control unit: fetches one instruction at a time, sequences decode,
// execute, memory and write-back, and owns the small register file.
module cu_multicycle #(
    parameter int DATA_WIDTH    = 8,
    parameter int REG_ADDR_BITS = 2,
    parameter int MEM_TIMEOUT   = 16,
    localparam int INSTR_WIDTH  = 6 + 3 * REG_ADDR_BITS + DATA_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INSTR_WIDTH-1:0]   instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    input  logic [DATA_WIDTH-1:0]    result2,
    input  logic                     mem_ack,
    output logic [DATA_WIDTH-1:0]    operand1,
    output logic [DATA_WIDTH-1:0]    operand2,
    output logic [DATA_WIDTH-1:0]    offset,
    output logic [3:0]               opcode,
    output logic                     sel1,
    output logic                     sel3,
    output logic                     w_r,
    output logic                     mem_req,
    output logic                     busy,
    output logic                     done,
    output logic                     err,
    input  logic [REG_ADDR_BITS-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]    dbg_data
);

    localparam int NUM_REGS = 2 ** REG_ADDR_BITS;
    localparam int CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    localparam logic [1:0] CLS_NOP   = 2'b00;
    localparam logic [1:0] CLS_STD   = 2'b01;
    localparam logic [1:0] CLS_LOAD  = 2'b10;
    localparam logic [1:0] CLS_STORE = 2'b11;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DECODE     = 3'd1,
        EXECUTE    = 3'd2,
        MEM_ACCESS = 3'd3,
        WRITE_BACK = 3'd4
    } state_t;

    state_t                   state_reg, state_next;
    logic [INSTR_WIDTH-1:0]   instr_reg;
    logic [CNT_W-1:0]         timer_reg;
    logic                     done_reg, done_next;
    logic                     err_reg, err_next;
    logic                     timeout_hit;
    logic [DATA_WIDTH-1:0]    regs [NUM_REGS];

    // Field slices of the latched instruction (MSB to LSB: class, rd, rs1, rs2, offset, alu_op)
    logic [1:0]               cls_in;
    logic [1:0]               cls_reg;
    logic [REG_ADDR_BITS-1:0] rd_reg, rs1_reg, rs2_reg;
    logic [DATA_WIDTH-1:0]    offset_field;
    logic [3:0]               alu_op_field;

    assign cls_in       = instr[INSTR_WIDTH-1 -: 2];
    assign cls_reg      = instr_reg[INSTR_WIDTH-1 -: 2];
    assign rd_reg       = instr_reg[4 + DATA_WIDTH + 2 * REG_ADDR_BITS +: REG_ADDR_BITS];
    assign rs1_reg      = instr_reg[4 + DATA_WIDTH + REG_ADDR_BITS +: REG_ADDR_BITS];
    assign rs2_reg      = instr_reg[4 + DATA_WIDTH +: REG_ADDR_BITS];
    assign offset_field = instr_reg[4 +: DATA_WIDTH];
    assign alu_op_field = instr_reg[3:0];

    assign timeout_hit = (MEM_TIMEOUT > 0) && (int'(timer_reg) == MEM_TIMEOUT - 1);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic, including the completion/abort strobes
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        err_next   = 1'b0;
        case (state_reg)
            IDLE: begin
                if (instr_valid && cls_in != CLS_NOP) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                state_next = EXECUTE;
            end
            EXECUTE: begin
                state_next = (cls_reg == CLS_STD) ? WRITE_BACK : MEM_ACCESS;
            end
            MEM_ACCESS: begin
                // An acknowledge on the final allowed cycle wins over the timeout.
                if (mem_ack) begin
                    if (cls_reg == CLS_LOAD) begin
                        state_next = WRITE_BACK;
                    end else begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else if (timeout_hit) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
            WRITE_BACK: begin
                state_next = IDLE;
                done_next  = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic decoded from the current state
    always_comb begin
        instr_ready = 1'b0;
        busy        = 1'b1;
        mem_req     = 1'b0;
        w_r         = 1'b0;
        case (state_reg)
            IDLE: begin
                instr_ready = 1'b1;
                busy        = 1'b0;
            end
            MEM_ACCESS: begin
                mem_req = 1'b1;
                w_r     = (cls_reg == CLS_STORE);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_reg <= '0;
            timer_reg <= '0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            if (state_reg == IDLE && instr_valid) begin
                instr_reg <= instr;
            end
            if (state_reg == MEM_ACCESS && state_next == MEM_ACCESS) begin
                timer_reg <= timer_reg + 1'b1;
            end else begin
                timer_reg <= '0;
            end
            done_reg <= done_next;
            err_reg  <= err_next;
        end
    end

    assign done = done_reg;
    assign err  = err_reg;

    // Operand outputs are captured once at decode and held until the next real instruction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            operand1 <= '0;
            operand2 <= '0;
            offset   <= '0;
            opcode   <= 4'hF;
            sel1     <= 1'b0;
            sel3     <= 1'b0;
        end else if (state_reg == DECODE) begin
            operand1 <= regs[rs1_reg];
            offset   <= offset_field;
            opcode   <= alu_op_field;
            if (cls_reg == CLS_STD) begin
                operand2 <= regs[rs2_reg];
                sel1     <= 1'b1;
                sel3     <= 1'b0;
            end else begin
                operand2 <= regs[rd_reg];
                sel1     <= 1'b0;
                sel3     <= 1'b1;
            end
        end
    end

    // Register file: each entry resets to its own index; written only when leaving write-back.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= DATA_WIDTH'(i);
            end
        end else if (state_reg == WRITE_BACK) begin
            regs[rd_reg] <= result2;
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule
